// File: rtl/mac_job_sequencer_if.sv
// Bundles the job, operand, MAC and result signals of mac_job_sequencer.
// The slave modport is the sequencer's view; the master modport is the initiator and MAC side.
interface mac_job_sequencer_if #(
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             in_vld;
   logic             in_rdy;
   logic [7:0]       in_a;
   logic [7:0]       in_b;
   logic             mac_clr;
   logic             mac_en;
   logic [7:0]       mac_a;
   logic [7:0]       mac_b;
   logic [63:0]      mac_accum;
   logic             res_vld;
   logic             res_rdy;
   logic [63:0]      res_data;

   modport slave (
      input  start, len, in_vld, in_a, in_b, mac_accum, res_rdy,
      output busy, in_rdy, mac_clr, mac_en, mac_a, mac_b, res_vld, res_data
   );

   modport master (
      output start, len, in_vld, in_a, in_b, mac_accum, res_rdy,
      input  busy, in_rdy, mac_clr, mac_en, mac_a, mac_b, res_vld, res_data
   );
endinterface

// File: rtl/mac_job_sequencer.sv
// Job controller for an 8x8 MAC: clears it, streams LEN operand pairs, waits out
// the MAC pipeline, then hands the final accumulator back over a valid/ready port.
module mac_job_sequencer #(
   parameter int LEN_W     = 8,
   parameter int DRAIN_CYC = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mac_job_sequencer_if.slave   bus
);
   localparam int DW = $clog2(DRAIN_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic [DW-1:0]    r_drain;
   logic             r_busy;
   logic             r_in_rdy;
   logic             r_mac_clr;
   logic             r_mac_en;
   logic [7:0]       r_mac_a;
   logic [7:0]       r_mac_b;
   logic             r_res_vld;
   logic [63:0]      r_res_data;

   logic             w_accept;
   logic             w_last_pair;
   logic             w_drain_done;

   assign w_accept     = r_in_rdy & bus.in_vld;
   assign w_last_pair  = (r_cnt == r_len - LEN_W'(1));
   assign w_drain_done = (r_drain == DW'(DRAIN_CYC));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_cnt      <= '0;
         r_drain    <= '0;
         r_busy     <= 1'b0;
         r_in_rdy   <= 1'b0;
         r_mac_clr  <= 1'b0;
         r_mac_en   <= 1'b0;
         r_mac_a    <= '0;
         r_mac_b    <= '0;
         r_res_vld  <= 1'b0;
         r_res_data <= '0;
      end else begin
         // clr and en are single-cycle strobes unless re-armed below
         r_mac_clr <= 1'b0;
         r_mac_en  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_len     <= bus.len;
                  r_busy    <= 1'b1;
                  r_mac_clr <= 1'b1;
                  r_state   <= S_CLR;
               end
            end
            S_CLR: begin
               r_cnt   <= '0;
               r_drain <= '0;
               if (r_len == '0) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_in_rdy <= 1'b1;
                  r_state  <= S_FEED;
               end
            end
            S_FEED: begin
               if (w_accept) begin
                  r_mac_en <= 1'b1;
                  r_mac_a  <= bus.in_a;
                  r_mac_b  <= bus.in_b;
                  r_cnt    <= r_cnt + LEN_W'(1);
                  if (w_last_pair) begin
                     r_in_rdy <= 1'b0;
                     r_state  <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               // the extra cycle beyond DRAIN_CYC lets the MAC output register settle
               if (w_drain_done) begin
                  r_res_data <= bus.mac_accum;
                  r_res_vld  <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_drain <= r_drain + DW'(1);
               end
            end
            S_DONE: begin
               if (bus.res_rdy) begin
                  r_res_vld <= 1'b0;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.in_rdy   = r_in_rdy;
   assign bus.mac_clr  = r_mac_clr;
   assign bus.mac_en   = r_mac_en;
   assign bus.mac_a    = r_mac_a;
   assign bus.mac_b    = r_mac_b;
   assign bus.res_vld  = r_res_vld;
   assign bus.res_data = r_res_data;
endmodule
